// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: the transmit controller
// state encoding and the TX line-select codes that the TX mux and RX side
// also use.
//
// Contents:
//    tx_state_t     - controller states IDLE, START, DATA, PARITY, STOP
//    MUX_START      - line select for the start bit (line driven 0)
//    MUX_STOP       - line select for the stop bit and idle (line driven 1)
//    MUX_DATA       - line select for the serializer output
//    MUX_PAR        - line select for the parity bit
//    mux_for_state  - line select that belongs to each controller state
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   localparam logic [1:0] MUX_START = 2'b00;
   localparam logic [1:0] MUX_STOP  = 2'b01;
   localparam logic [1:0] MUX_DATA  = 2'b10;
   localparam logic [1:0] MUX_PAR   = 2'b11;

   // Idle and stop both hold the line high, so they share MUX_STOP.
   function automatic logic [1:0] mux_for_state(input tx_state_t state);
      logic [1:0] sel;
      sel = MUX_STOP;
      case (state)
         ST_START:  sel = MUX_START;
         ST_DATA:   sel = MUX_DATA;
         ST_PARITY: sel = MUX_PAR;
         default:   sel = MUX_STOP;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// ---------------------------------------------------------------------------
// parity_calc
// Combinational parity generator for one byte.
//
// Ports:
//    data     in  8  byte to protect
//    par_typ  in  1  0 = even parity, 1 = odd parity
//    par_bit  out 1  parity bit that makes the total count of ones even/odd
// ---------------------------------------------------------------------------
module parity_calc (
   input  logic [7:0] data,
   input  logic       par_typ,
   output logic       par_bit
);

   // XOR-reducing the byte gives the even-parity bit; odd parity is its
   // complement, which is the same as XORing in par_typ.
   assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Frame controller for a UART transmitter. Accepts a byte, then sequences
// the TX line through start bit, eight serial data bits (shifted by an
// external serializer), an optional parity bit and a stop bit. A frame can
// be accepted in the stop cycle of the previous one, so back-to-back frames
// have no idle gap. If the serializer never reports completion, the frame
// is abandoned after TIMEOUT data cycles and frame_err pulses once.
//
// Parameters:
//    TIMEOUT     max cycles spent in DATA waiting for ser_done (<= 16)
//
// Ports:
//    clk         in  1  rising-edge clock
//    rst         in  1  synchronous active-high reset
//    p_data      in  8  byte to send, sampled when the frame is accepted
//    data_valid  in  1  send request
//    par_en      in  1  parity enable, sampled at acceptance
//    par_typ     in  1  0 = even, 1 = odd, sampled at acceptance
//    ser_done    in  1  serializer has bit 7 on the line
//    ser_en      out 1  serializer enable
//    ser_data    out 8  latched byte for the serializer
//    mux_sel     out 2  TX line select (see uart_pkg MUX_* codes)
//    par_bit     out 1  parity bit of the latched byte
//    busy        out 1  frame in progress
//    frame_err   out 1  one-cycle pulse when the serializer times out
// ---------------------------------------------------------------------------
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int TIMEOUT = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] p_data,
   input  logic       data_valid,
   input  logic       par_en,
   input  logic       par_typ,
   input  logic       ser_done,
   output logic       ser_en,
   output logic [7:0] ser_data,
   output logic [1:0] mux_sel,
   output logic       par_bit,
   output logic       busy,
   output logic       frame_err
);

   // Counter value seen during the last DATA cycle we are willing to wait.
   localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

   tx_state_t  state;
   tx_state_t  next_state;
   logic [3:0] data_cnt;
   logic       lat_par_en;
   logic       lat_par_typ;
   logic       accept;
   logic       abort;

   // Next-state decision. A frame is accepted only from IDLE or STOP, so a
   // request arriving mid-frame is simply dropped. In DATA a completing
   // serializer always wins over the timeout, even on the same cycle.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      abort      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (data_valid) begin
               next_state = ST_START;
               accept     = 1'b1;
            end
         end
         ST_START: begin
            next_state = ST_DATA;
         end
         ST_DATA: begin
            if (ser_done) begin
               next_state = lat_par_en ? ST_PARITY : ST_STOP;
            end else if (data_cnt == TIMEOUT_LAST) begin
               next_state = ST_IDLE;
               abort      = 1'b1;
            end
         end
         ST_PARITY: begin
            next_state = ST_STOP;
         end
         ST_STOP: begin
            if (data_valid) begin
               next_state = ST_START;
               accept     = 1'b1;
            end else begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // State, DATA-cycle counter, frame latches and the error pulse. The
   // counter sits at zero outside DATA, so it is already cleared on entry
   // and counts the DATA cycles of this frame. Reset takes priority over
   // any pending abort, so a reset mid-frame never produces frame_err.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         data_cnt    <= 4'd0;
         ser_data    <= 8'h00;
         lat_par_en  <= 1'b0;
         lat_par_typ <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state     <= next_state;
         data_cnt  <= (state == ST_DATA) ? data_cnt + 4'd1 : 4'd0;
         frame_err <= abort;
         if (accept) begin
            ser_data    <= p_data;
            lat_par_en  <= par_en;
            lat_par_typ <= par_typ;
         end
      end
   end

   // The parity bit is derived from the latched byte and latched parity
   // type, so it equals the value computed from p_data at acceptance and
   // holds until the next acceptance (and is 0 after reset).
   parity_calc u_parity (
      .data    (ser_data),
      .par_typ (lat_par_typ),
      .par_bit (par_bit)
   );

   // Line select and busy come from the state register alone; only the
   // serializer enable looks at ser_done, dropping as soon as bit 7 is out.
   assign mux_sel = mux_for_state(state);
   assign busy    = (state != ST_IDLE);
   assign ser_en  = (state == ST_START) || ((state == ST_DATA) && !ser_done);

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 9, max cycles in DATA waiting for ser_done before abort.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 p_data  input  8  byte to transmit, sampled only at acceptance.
REQ-005 data_valid  input  1  request to send p_data.
REQ-006 par_en  input  1  parity enable, sampled at acceptance.
REQ-007 par_typ  input  1  0 = even, 1 = odd, sampled at acceptance.
REQ-008 ser_done  input  1  serializer done flag, high while bit 7 is on the line.
REQ-009 ser_en  output  1  serializer enable.
REQ-010 ser_data  output  8  latched byte driven to the serializer.
REQ-011 mux_sel  output  2  TX line select: 00 start(0), 01 stop/idle(1), 10 serial data, 11 parity.
REQ-012 par_bit  output  1  latched parity bit.
REQ-013 busy  output  1  frame in progress.
REQ-014 frame_err  output  1  one-cycle pulse on serializer timeout.

Function
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, one state per rising edge.
REQ-016 SHALL accept a frame when data_valid=1 in IDLE or STOP: latch p_data into ser_data, latch parity config, go to START next cycle.
REQ-017 SHALL ignore data_valid in START, DATA and PARITY; no queuing.
REQ-018 par_bit SHALL be ^p_data for even, ~^p_data for odd, computed from p_data at acceptance and held until next acceptance.
REQ-019 START SHALL last exactly 1 cycle: mux_sel=00, ser_en=1, then DATA.
REQ-020 DATA: mux_sel=10; ser_en = ~ser_done; leave DATA the cycle after ser_done=1 is sampled.
REQ-021 DATA exit SHALL go to PARITY if latched par_en=1, else STOP.
REQ-022 PARITY SHALL last 1 cycle with mux_sel=11, then STOP.
REQ-023 STOP SHALL last 1 cycle with mux_sel=01; next state START if data_valid=1 (back-to-back, zero idle gap), else IDLE.
REQ-024 IDLE: mux_sel=01, ser_en=0, busy=0.
REQ-025 busy SHALL be 1 in START, DATA, PARITY, STOP; mux_sel and busy decoded from state register only.
REQ-026 Frame length SHALL be 11 cycles busy with parity, 10 without, for a conforming serializer.
REQ-027 SHALL count DATA cycles with a 4-bit counter cleared on DATA entry; if counter reaches TIMEOUT without ser_done, pulse frame_err 1 cycle and go to IDLE.
REQ-028 ser_done=1 outside DATA SHALL be ignored.
REQ-029 ser_done and timeout on same cycle: ser_done wins, no frame_err.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, ser_data=8'h00, par_bit=0, counter=0, latched par_en/par_typ=0.
REQ-031 Outputs after reset: ser_en=0, mux_sel=01, busy=0, frame_err=0.
REQ-032 Reset mid-frame SHALL abort immediately with no frame_err and no residual pulse.
REQ-033 data_valid during the rst cycle SHALL not be accepted.

Structure
REQ-034 State encodings and mux_sel encodings (MUX_START, MUX_STOP, MUX_DATA, MUX_PAR) SHALL live in shared package uart_pkg, reused by TX mux and RX.
REQ-035 Parity calculation SHALL be a sub-module parity_calc (8-bit data, par_typ in, par_bit out, combinational).
REQ-036 The next-state logic SHALL be a single combinational block; state, counter and latches in one synchronous block.

Verification
REQ-037 0xA5, par_en=1, par_typ=0, ser_done modelled 8 cycles after DATA entry -> mux_sel 00,10x8,11,01; par_bit=0; busy 11 cycles.
REQ-038 0x01, par_en=1, par_typ=1 -> par_bit=0; par_typ=0 -> par_bit=1; par_en=0 -> no 11 on mux_sel, busy 10 cycles.
REQ-039 data_valid held high, bytes 0x3C then 0xC3 -> STOP directly followed by START, ser_data=0xC3 in second frame, busy never drops.
REQ-040 ser_done held low -> frame_err pulse 1 cycle after 9 DATA cycles, state IDLE, busy=0, ser_en=0.
REQ-041 rst asserted on 4th DATA cycle -> next cycle IDLE, mux_sel=01, ser_en=0, busy=0, frame_err=0.
REQ-042 data_valid pulsed during DATA and PARITY -> ignored; ser_data unchanged, returns to IDLE after STOP.
